// File: rtl/sig_framer_pkg.sv
// Shared definitions for the sig_framer slice: write-FSM states, frame length
// derivation and the test-pattern LFSR constants.
package sig_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    // x^32+x^22+x^2+x+1 with the newest bit shifted in at bit 0: the
    // x^22, x^2, x^1 and x^0 terms of the recurrence sit at bits 9, 29, 30, 31.
    localparam logic [31:0] LFSR_TAPS = 32'hE000_0200;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    function automatic int frame_len(input int loop0, input int loop1);
        return loop0 * loop1;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sig_framer_fifo.sv
// Synchronous FIFO of {first,last,qdata,idata}; exposes the head as it will be
// after this cycle's push/pop so the parent can register it directly.
module sig_framer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   sig_clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   push_first_i,
    input  logic                   push_last_i,
    input  logic [WIDTH-1:0]       push_idata_i,
    input  logic [WIDTH-1:0]       push_qdata_i,
    input  logic                   pop_i,
    input  logic                   retag_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   newest_last_o,
    output logic                   nxt_valid_o,
    output logic                   nxt_first_o,
    output logic                   nxt_last_o,
    output logic [WIDTH-1:0]       nxt_idata_o,
    output logic [WIDTH-1:0]       nxt_qdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_i_q [DEPTH];
    logic [WIDTH-1:0] mem_q_q [DEPTH];
    logic [DEPTH-1:0] mem_first_q;
    logic [DEPTH-1:0] mem_last_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, newest, rd_d;
    logic [LW-1:0]    level_q, remain, level_d;

    always_comb begin
        newest      = wr_ptr_q - AW'(1);
        rd_d        = rd_ptr_q + AW'(pop_i);
        remain      = level_q - LW'(pop_i);
        level_d     = remain + LW'(push_i);
        nxt_valid_o = (level_d != '0);
        if (remain != '0) begin
            // a retag landing on the next head must be visible in the same cycle
            nxt_first_o = mem_first_q[rd_d];
            nxt_last_o  = mem_last_q[rd_d] | (retag_i && (rd_d == newest));
            nxt_idata_o = mem_i_q[rd_d];
            nxt_qdata_o = mem_q_q[rd_d];
        end else begin
            nxt_first_o = push_first_i;
            nxt_last_o  = push_last_i;
            nxt_idata_o = push_idata_i;
            nxt_qdata_o = push_qdata_i;
        end
    end

    always_ff @(posedge sig_clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge sig_clock) begin
        if (push_i) begin
            mem_i_q[wr_ptr_q]     <= push_idata_i;
            mem_q_q[wr_ptr_q]     <= push_qdata_i;
            mem_first_q[wr_ptr_q] <= push_first_i;
            mem_last_q[wr_ptr_q]  <= push_last_i;
        end
        if (retag_i) mem_last_q[newest] <= 1'b1;
    end

    assign level_o       = level_q;
    assign newest_last_o = mem_last_q[newest];

endmodule

// File: rtl/sig_framer.sv
// Framed I/Q sample source: write FSM tags first/last every LOOP0*LOOP1 samples,
// FIFO buffers, registered AXI-S output. SIG_FRAMER_PRBS_EN adds an LFSR test source.
module sig_framer
    import sig_framer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOOP0 = 3,
    parameter int LOOP1 = 5,
    parameter int DEPTH = 16,
    parameter int FBITS = 16
) (
    input  logic                   sig_clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   raw_valid_i,
    input  logic [WIDTH-1:0]       raw_idata_i,
    input  logic [WIDTH-1:0]       raw_qdata_i,
    output logic                   sig_valid_o,
    input  logic                   sig_ready_i,
    output logic                   sig_first_o,
    output logic                   sig_last_o,
    output logic [WIDTH-1:0]       sig_idata_o,
    output logic [WIDTH-1:0]       sig_qdata_o,
    output logic                   overflow_o,
    input  logic                   clear_i,
`ifdef SIG_FRAMER_PRBS_EN
    input  logic                   test_i,
`endif
    output logic [FBITS-1:0]       frames_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int COUNT = frame_len(LOOP0, LOOP1);
    localparam int CW    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

    wr_state_e        state_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic [FBITS-1:0] frames_q;
    logic             sig_valid_q, sig_first_q, sig_last_q;
    logic [WIDTH-1:0] sig_idata_q, sig_qdata_q;

    logic [WIDTH-1:0] in_idata, in_qdata;
    logic [LW-1:0]    fifo_level;
    logic             newest_last, nxt_valid, nxt_first, nxt_last;
    logic [WIDTH-1:0] nxt_idata, nxt_qdata;
    logic             full, wrap, take, push, ovf, retag, pop;

`ifdef SIG_FRAMER_PRBS_EN
    logic [31:0] lfsr_q;

    // advances on every strobe, dropped or ignored, so the pattern tracks the front end
    always_ff @(posedge sig_clock) begin
        if (reset)            lfsr_q <= LFSR_SEED;
        else if (raw_valid_i) lfsr_q <= lfsr_step(lfsr_q);
    end

    assign in_idata = test_i ? lfsr_q[WIDTH-1:0]  : raw_idata_i;
    assign in_qdata = test_i ? ~lfsr_q[WIDTH-1:0] : raw_qdata_i;
`else
    assign in_idata = raw_idata_i;
    assign in_qdata = raw_qdata_i;
`endif

    always_comb begin
        full  = (fifo_level == LW'(DEPTH));
        wrap  = (count_q == CNT_LAST);
        take  = raw_valid_i && ((state_q != ST_IDLE) || enable_i);
        push  = take && (state_q != ST_DROP) && !full;
        ovf   = take && (state_q != ST_DROP) && full;
        retag = ovf && !newest_last;
        pop   = sig_valid_q && sig_ready_i;
    end

    sig_framer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sig_clock     (sig_clock),
        .reset         (reset),
        .push_i        (push),
        .push_first_i  (count_q == '0),
        .push_last_i   (wrap),
        .push_idata_i  (in_idata),
        .push_qdata_i  (in_qdata),
        .pop_i         (pop),
        .retag_i       (retag),
        .level_o       (fifo_level),
        .newest_last_o (newest_last),
        .nxt_valid_o   (nxt_valid),
        .nxt_first_o   (nxt_first),
        .nxt_last_o    (nxt_last),
        .nxt_idata_o   (nxt_idata),
        .nxt_qdata_o   (nxt_qdata)
    );

    always_ff @(posedge sig_clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frames_q    <= '0;
            sig_valid_q <= 1'b0;
            sig_first_q <= 1'b0;
            sig_last_q  <= 1'b0;
            sig_idata_q <= '0;
            sig_qdata_q <= '0;
        end else begin
            if (take) begin
                count_q <= wrap ? '0 : count_q + CW'(1);
                case (state_q)
                    ST_DROP: if (wrap) state_q <= ST_IDLE;
                    default: begin
                        // a drop on the frame's final slot has nothing left to discard
                        if (full)                  state_q <= wrap ? ST_IDLE : ST_DROP;
                        else if (wrap && !enable_i) state_q <= ST_IDLE;
                        else                       state_q <= ST_FILL;
                    end
                endcase
            end
            if (ovf)          overflow_q <= 1'b1;
            else if (clear_i) overflow_q <= 1'b0;
            if (pop && sig_last_q) frames_q <= frames_q + FBITS'(1);
            sig_valid_q <= nxt_valid;
            sig_first_q <= nxt_first;
            sig_last_q  <= nxt_last;
            sig_idata_q <= nxt_idata;
            sig_qdata_q <= nxt_qdata;
        end
    end

    assign sig_valid_o = sig_valid_q;
    assign sig_first_o = sig_first_q;
    assign sig_last_o  = sig_last_q;
    assign sig_idata_o = sig_idata_q;
    assign sig_qdata_o = sig_qdata_q;
    assign overflow_o  = overflow_q;
    assign frames_o    = frames_q;
    assign level_o     = fifo_level;

endmodule

// File: tb/tb_sig_framer.sv
// Directed bench for sig_framer: scoreboard of expected beats checked on each
// output handshake, plus framing, overflow, clear and reset checks.
module tb_sig_framer;

    logic        sig_clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic        raw_valid_i = 1'b0;
    logic [31:0] raw_idata_i = '0;
    logic [31:0] raw_qdata_i = '0;
    logic        sig_ready_i = 1'b0;
    logic        clear_i = 1'b0;
`ifdef SIG_FRAMER_PRBS_EN
    logic        test_i = 1'b0;
`endif
    logic        sig_valid_o, sig_first_o, sig_last_o, overflow_o;
    logic [31:0] sig_idata_o, sig_qdata_o;
    logic [15:0] frames_o;
    logic [4:0]  level_o;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] idata;
        logic [31:0] qdata;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_fail = 0;

    sig_framer dut (
        .sig_clock   (sig_clock),
        .reset       (reset),
        .enable_i    (enable_i),
        .raw_valid_i (raw_valid_i),
        .raw_idata_i (raw_idata_i),
        .raw_qdata_i (raw_qdata_i),
        .sig_valid_o (sig_valid_o),
        .sig_ready_i (sig_ready_i),
        .sig_first_o (sig_first_o),
        .sig_last_o  (sig_last_o),
        .sig_idata_o (sig_idata_o),
        .sig_qdata_o (sig_qdata_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i),
`ifdef SIG_FRAMER_PRBS_EN
        .test_i      (test_i),
`endif
        .frames_o    (frames_o),
        .level_o     (level_o)
    );

    always #5 sig_clock = ~sig_clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic tick();
        beat_t e;
        if (sig_valid_o && sig_ready_i) begin
            n_chk++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed beat idata=%0h expected no beat", sig_idata_o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat", {sig_first_o, sig_last_o, sig_idata_o, sig_qdata_o}, e);
            end
        end
        @(posedge sig_clock);
        @(negedge sig_clock);
    endtask

    task automatic send(input logic [31:0] d, input logic en, input bit exp_out,
                        input logic f, input logic l);
        enable_i    = en;
        raw_valid_i = 1'b1;
        raw_idata_i = d;
        raw_qdata_i = ~d;
        if (exp_out) sb.push_back({f, l, d, ~d});
        tick();
        raw_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        raw_valid_i = 1'b0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 128'(sb.size()), 128'd0);
    endtask

    task automatic do_reset();
        sig_ready_i = 1'b0;
        raw_valid_i = 1'b0;
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        @(negedge sig_clock);
        do_reset();
        chk("rst_valid", 128'(sig_valid_o), 128'd0);
        chk("rst_tags", 128'({sig_first_o, sig_last_o}), 128'd0);
        chk("rst_data", 128'({sig_idata_o, sig_qdata_o}), 128'd0);
        chk("rst_level", 128'(level_o), 128'd0);
        chk("rst_frames", 128'(frames_o), 128'd0);
        chk("rst_ovf", 128'(overflow_o), 128'd0);

        // two back-to-back frames, always ready
        sig_ready_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send(32'(k), 1'b1, 1'b1, (k % 15) == 0, (k % 15) == 14);
            if (k == 0) begin
                chk("lat_valid", 128'(sig_valid_o), 128'd1);
                chk("lat_data", 128'(sig_idata_o), 128'd0);
            end
        end
        drain("s1_drain");
        chk("s1_frames", 128'(frames_o), 128'd2);
        chk("s1_level", 128'(level_o), 128'd0);

        // enable dropped mid-frame: the frame still completes, then samples are ignored
        do_reset();
        sig_ready_i = 1'b1;
        for (int k = 0; k < 20; k++)
            send(32'(100 + k), k < 7, k < 15, k == 0, k == 14);
        drain("s2_drain");
        chk("s2_frames", 128'(frames_o), 128'd1);
        send(32'd300, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("s2_restart");

        // overflow with the sink stalled
        do_reset();
        for (int k = 0; k < 16; k++)
            send(32'(k), 1'b1, 1'b1, (k == 0) || (k == 15), (k == 14) || (k == 15));
        chk("s3_level_full", 128'(level_o), 128'd16);
        chk("s3_ovf_before", 128'(overflow_o), 128'd0);
        clear_i = 1'b1;
        send(32'd16, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_i = 1'b0;
        chk("s3_ovf_set_wins", 128'(overflow_o), 128'd1);
        for (int k = 17; k < 31; k++)
            send(32'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s3_level_held", 128'(level_o), 128'd16);
        chk("s3_ovf_sticky", 128'(overflow_o), 128'd1);
        chk("s3_head_hold", 128'({sig_valid_o, sig_first_o, sig_last_o, sig_idata_o}),
            128'({1'b1, 1'b1, 1'b0, 32'd0}));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("s3_ovf_clear", 128'(overflow_o), 128'd0);
        sig_ready_i = 1'b1;
        drain("s3_drain");
        chk("s3_frames", 128'(frames_o), 128'd2);
        // sample 30 opened a dropped frame; its remaining 14 slots are discarded
        for (int k = 0; k < 14; k++)
            send(32'(400 + k), 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'd500, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("s3_resync");

        // reset mid-frame while output is valid
        sig_ready_i = 1'b0;
        send(32'd501, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'd502, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s4_pre_valid", 128'(sig_valid_o), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s4_valid", 128'(sig_valid_o), 128'd0);
        chk("s4_level", 128'(level_o), 128'd0);
        chk("s4_frames", 128'(frames_o), 128'd0);
        sig_ready_i = 1'b1;
        for (int k = 0; k < 15; k++)
            send(32'(600 + k), 1'b1, 1'b1, k == 0, k == 14);
        drain("s4_drain");
        chk("s4_frames_after", 128'(frames_o), 128'd1);

`ifdef SIG_FRAMER_PRBS_EN
        do_reset();
        test_i = 1'b1;
        sig_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enable_i    = 1'b1;
            raw_valid_i = 1'b1;
            raw_idata_i = 32'hA5A5_0000 + 32'(k);
            raw_qdata_i = '0;
            sb.push_back({k == 0, 1'b0, 32'h1 << k, ~(32'h1 << k)});
            tick();
        end
        drain("prbs_drain");
        test_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_framer.md
Name: sig_framer

Overview:
Framed antenna-sample source for the correlator, running entirely in the sig_clock domain. It takes raw I/Q samples from the acquisition front end and buffers them in a small FIFO. It emits an AXI4-Stream with first/last tags every LOOP0*LOOP1 samples, which replaces the testbench-only sample streaming. On overflow it truncates the current frame cleanly and resynchronises at the next frame boundary.

Parameters:
WIDTH, 32, bits per I or Q lane (one bit per antenna).
LOOP0, 3, inner correlator loop count.
LOOP1, 5, outer correlator loop count; frame length COUNT = LOOP0*LOOP1.
DEPTH, 16, FIFO entries; power of two, >= 2.
FBITS, 16, width of the frame counter.

Ports:
sig_clock  in  1  sole clock.
reset  in  1  synchronous reset, active-high.
enable_i  in  1  arm framing; deassertion takes effect at the next frame boundary.
raw_valid_i  in  1  raw sample strobe; no backpressure toward the front end.
raw_idata_i  in  WIDTH  I-lane sample.
raw_qdata_i  in  WIDTH  Q-lane sample.
sig_valid_o  out  1  AXI-S valid.
sig_ready_i  in  1  AXI-S ready.
sig_first_o  out  1  first word of frame.
sig_last_o  out  1  last word of frame.
sig_idata_o  out  WIDTH  I data.
sig_qdata_o  out  WIDTH  Q data.
overflow_o  out  1  sticky; set when a sample is dropped.
clear_i  in  1  clears overflow_o.
frames_o  out  FBITS  frames emitted, counted on the last-word handshake; wraps.
level_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, write FSM in IDLE, sample counter 0, frame counter 0. Reset mid-frame discards the partial frame; no last is ever emitted for it.
- Write FSM, IDLE: on enable_i && raw_valid_i, push the sample tagged first, set count=1, go to FILL. Samples arriving while enable_i=0 are ignored.
- Write FSM, FILL: each raw_valid_i pushes a sample and increments count.
  - The sample at count==COUNT-1 is tagged last; count resets to 0.
  - At that boundary, go to IDLE if enable_i=0, otherwise stay in FILL with the next sample tagged first.
- Full: level==DEPTH, evaluated before this cycle's pop. A simultaneous pop does not admit the push.
- Overflow (raw_valid_i while full, in IDLE or FILL):
  - The sample is dropped and overflow_o is set.
  - If the newest stored entry is not tagged last, set its last tag. It is guaranteed unread, so the frame is truncated early.
  - Go to DROP and keep advancing count.
- DROP: discard samples until the dropped frame's count would reach COUNT-1, then go to IDLE.
- Truncated frames are counted in frames_o.
- Read side:
  - FIFO head is presented on sig_* with registered outputs.
  - Latency: sample pushed in cycle N appears with sig_valid_o=1 in cycle N+1 when the FIFO was empty.
  - Data, first and last stay stable while valid && !ready.
  - Pop on valid && ready.
- Push and pop in the same cycle (not full): level unchanged.
- clear_i: clears overflow_o; if an overflow occurs in the same cycle, set wins.
- frames_o increments on sig_valid_o && sig_ready_i && sig_last_o; it wraps modulo 2^FBITS.

Optional Feature:
SIG_FRAMER_PRBS_EN
- Defined: adds input port test_i. When test_i=1, raw data is replaced by a 32-bit Fibonacci LFSR with taps x^32+x^22+x^2+x+1 and seed 32'h1 after reset.
  - I lane = lfsr[WIDTH-1:0], Q lane = ~lfsr[WIDTH-1:0].
  - The LFSR advances once per raw_valid_i, including dropped samples.
- Undefined: no test_i port, no LFSR logic; raw data passes straight through.

Decomposition:
- Shared include/package sig_framer_pkg: write-FSM state encodings (IDLE/FILL/DROP), LFSR polynomial and seed constants, COUNT derivation.
- Sub-module sig_framer_fifo: synchronous FIFO of {first,last,qdata,idata} with an occupancy output and a "retag newest as last" strobe. The framer FSM plus output register stay in sig_framer.

Test Plan:
- Reset, enable_i=1, sig_ready_i=1, 30 consecutive samples 0..29 -> two frames; first on 0 and 15, last on 14 and 29; data in order; one-cycle latency; frames_o=2.
- enable_i dropped while sample 7 is pushed -> frame completes through sample 14; samples 15+ ignored; frames_o=1; FSM in IDLE.
- sig_ready_i=0, push 31 samples -> samples 0..15 stored; sample 16 dropped; overflow_o=1; sample 15 retagged first+last; samples 17..29 dropped; sample 30 dropped (FIFO still full, 1-entry truncated frame). Then ready=1 -> one 15-word frame followed by one 1-word frame; frames_o=2.
- clear_i asserted alone -> overflow_o=0 next cycle. clear_i coincident with an overflow -> overflow_o stays 1.
- reset pulsed mid-frame with sig_valid_o=1 -> next cycle sig_valid_o=0, level_o=0, frames_o=0. Next accepted sample is tagged first.
- SIG_FRAMER_PRBS_EN, test_i=1 -> first I words 0x00000001, 0x00000002, 0x00000004 (per LFSR shift); Q = bitwise complement; framing unchanged.
